// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: decode redirects, instruction memory port and fetch outputs.
interface fetch_unit_if;
  logic        Stall_F;
  logic        Branch_Taken_D;
  logic [31:0] Branch_Target_D;
  logic        Jump_D;
  logic [31:0] Jump_Target_D;
  logic        Resume;
  logic [31:0] IM_RD;
  logic [31:0] IM_Addr;
  logic [31:0] Instr_F;
  logic [31:0] PC_Plus_One_F;
  logic        Flush_D;
  logic        Halted;
  logic [31:0] Fetch_Count;

  modport master (
    output Stall_F, Branch_Taken_D, Branch_Target_D, Jump_D, Jump_Target_D, Resume, IM_RD,
    input  IM_Addr, Instr_F, PC_Plus_One_F, Flush_D, Halted, Fetch_Count
  );

  modport slave (
    input  Stall_F, Branch_Taken_D, Branch_Target_D, Jump_D, Jump_Target_D, Resume, IM_RD,
    output IM_Addr, Instr_F, PC_Plus_One_F, Flush_D, Halted, Fetch_Count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, decode redirects, halt/resume and fetch counting.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input logic       clk,
  input logic       reset,
  fetch_unit_if.slave f
);
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;

  logic        run;
  logic        redirect;
  logic        halt_det;
  logic [31:0] pc_inc;

  assign run      = (state_q == RUN);
  assign pc_inc   = pc_q + 32'd1;
  assign redirect = (f.Branch_Taken_D | f.Jump_D) & ~f.Stall_F & run;
  assign halt_det = run & ~f.Stall_F & ~redirect & (f.IM_RD[31:26] == HALT_OPCODE);

  assign f.IM_Addr       = pc_q;
  assign f.PC_Plus_One_F = pc_inc;
  assign f.Flush_D       = redirect;
  assign f.Halted        = (state_q == HALT);
  assign f.Fetch_Count   = cnt_q;
  // Halt instruction itself is replaced by a NOP so decode never sees it.
  assign f.Instr_F       = (run && !halt_det) ? f.IM_RD : 32'h0000_0000;

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (run) begin
      if (f.Stall_F) begin
        pc_d = pc_q;
      end else if (f.Branch_Taken_D) begin
        pc_d = f.Branch_Target_D;
      end else if (f.Jump_D) begin
        pc_d = f.Jump_Target_D;
      end else if (halt_det) begin
        pc_d    = pc_q;
        state_d = HALT;
      end else begin
        pc_d = pc_inc;
        if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
      end
    end else if (f.Resume) begin
      pc_d    = pc_inc;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      cnt_q   <= 32'h0000_0000;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus a hand-written stall sequence.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;

  localparam logic [31:0] N = 32'h2001_0005;
  localparam logic [31:0] H = 32'hFC00_0000;

  fetch_unit_if ifc();

  fetch_unit #(.RESET_PC(32'h0), .HALT_OPCODE(6'b111111)) dut (
    .clk(clk), .reset(reset), .f(ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, bt;
    logic [31:0] btgt;
    logic        j;
    logic [31:0] jtgt;
    logic        res;
    logic [31:0] imrd;
    logic [31:0] addr, instr, ppo;
    logic        flush, halted;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic rst, logic stall, logic bt, logic [31:0] btgt,
                              logic j, logic [31:0] jtgt, logic res, logic [31:0] imrd,
                              logic [31:0] addr, logic [31:0] instr, logic [31:0] ppo,
                              logic flush, logic halted, logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.bt = bt; v.btgt = btgt; v.j = j; v.jtgt = jtgt;
    v.res = res; v.imrd = imrd; v.addr = addr; v.instr = instr; v.ppo = ppo;
    v.flush = flush; v.halted = halted; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(logic rst, logic stall, logic bt, logic [31:0] btgt,
                       logic j, logic [31:0] jtgt, logic res, logic [31:0] imrd);
    reset = rst; ifc.Stall_F = stall; ifc.Branch_Taken_D = bt; ifc.Branch_Target_D = btgt;
    ifc.Jump_D = j; ifc.Jump_Target_D = jtgt; ifc.Resume = res; ifc.IM_RD = imrd;
  endtask

  task automatic check_all(string tag, logic [31:0] addr, logic [31:0] instr, logic [31:0] ppo,
                           logic flush, logic halted, logic [31:0] cnt);
    chk({tag, ".IM_Addr"}, ifc.IM_Addr, addr);
    chk({tag, ".Instr_F"}, ifc.Instr_F, instr);
    chk({tag, ".PC_Plus_One_F"}, ifc.PC_Plus_One_F, ppo);
    chk({tag, ".Flush_D"}, {31'b0, ifc.Flush_D}, {31'b0, flush});
    chk({tag, ".Halted"}, {31'b0, ifc.Halted}, {31'b0, halted});
    chk({tag, ".Fetch_Count"}, ifc.Fetch_Count, cnt);
  endtask

  initial begin
    //             rst st bt btgt          j  jtgt     res imrd          addr          instr  ppo           fl ha cnt
    tbl[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0,  0, N,            32'h0,        N,     32'h1,        0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,  0, N,            32'h1,        N,     32'h2,        0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,  0, N,            32'h2,        N,     32'h3,        0, 0, 2);
    tbl[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,  0, N,            32'h3,        N,     32'h4,        0, 0, 3);
    tbl[4]  = mk(0, 0, 1, 32'h7,        0, 32'h0,  0, N,            32'h4,        N,     32'h5,        1, 0, 4);
    tbl[5]  = mk(0, 0, 1, 32'h40,       1, 32'h80, 0, N,            32'h7,        N,     32'h8,        1, 0, 4);
    tbl[6]  = mk(0, 0, 0, 32'h0,        1, 32'h5,  0, N,            32'h40,       N,     32'h41,       1, 0, 4);
    tbl[7]  = mk(0, 1, 1, 32'h99,       0, 32'h0,  0, N,            32'h5,        N,     32'h6,        0, 0, 4);
    tbl[8]  = mk(0, 1, 1, 32'h99,       0, 32'h0,  0, N,            32'h5,        N,     32'h6,        0, 0, 4);
    tbl[9]  = mk(0, 1, 1, 32'h99,       0, 32'h0,  0, N,            32'h5,        N,     32'h6,        0, 0, 4);
    tbl[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,  0, N,            32'h5,        N,     32'h6,        0, 0, 4);
    tbl[11] = mk(0, 0, 1, 32'h9,        0, 32'h0,  0, N,            32'h6,        N,     32'h7,        1, 0, 5);
    tbl[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,  0, H,            32'h9,        32'h0, 32'hA,        0, 0, 5);
    tbl[13] = mk(0, 0, 0, 32'h0,        1, 32'h80, 0, N,            32'h9,        32'h0, 32'hA,        0, 1, 5);
    tbl[14] = mk(0, 1, 1, 32'h33,       0, 32'h0,  0, N,            32'h9,        32'h0, 32'hA,        0, 1, 5);
    tbl[15] = mk(0, 0, 0, 32'h0,        0, 32'h0,  1, N,            32'h9,        32'h0, 32'hA,        0, 1, 5);
    tbl[16] = mk(0, 0, 0, 32'h0,        0, 32'h0,  1, N,            32'hA,        N,     32'hB,        0, 0, 5);
    tbl[17] = mk(0, 0, 1, 32'hFFFFFFFF, 0, 32'h0,  0, N,            32'hB,        N,     32'hC,        1, 0, 6);
    tbl[18] = mk(0, 0, 0, 32'h0,        0, 32'h0,  0, N,            32'hFFFFFFFF, N,     32'h0,        0, 0, 6);
    tbl[19] = mk(0, 1, 0, 32'h0,        0, 32'h0,  0, H,            32'h0,        H,     32'h1,        0, 0, 7);
    tbl[20] = mk(0, 0, 0, 32'h0,        1, 32'h3,  0, H,            32'h0,        H,     32'h1,        1, 0, 7);
    tbl[21] = mk(0, 0, 0, 32'h0,        0, 32'h0,  0, 32'hFC000001, 32'h3,        32'h0, 32'h4,        0, 0, 7);
    tbl[22] = mk(1, 1, 0, 32'h0,        0, 32'h0,  0, N,            32'h3,        32'h0, 32'h4,        0, 1, 7);
    tbl[23] = mk(1, 0, 1, 32'h55,       0, 32'h0,  0, N,            32'h0,        N,     32'h1,        1, 0, 0);
    tbl[24] = mk(0, 0, 0, 32'h0,        0, 32'h0,  0, N,            32'h0,        N,     32'h1,        0, 0, 0);
    tbl[25] = mk(0, 0, 0, 32'h0,        0, 32'h0,  0, N,            32'h1,        N,     32'h2,        0, 0, 1);

    drive(1, 0, 0, 0, 0, 0, 0, N);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].stall, tbl[i].bt, tbl[i].btgt, tbl[i].j, tbl[i].jtgt,
            tbl[i].res, tbl[i].imrd);
      #2;
      check_all($sformatf("vec%0d", i), tbl[i].addr, tbl[i].instr, tbl[i].ppo,
                tbl[i].flush, tbl[i].halted, tbl[i].cnt);
    end

    // Long stall with a pending jump: PC and count frozen, then normal sequencing resumes.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 1, 0, 0, 1, 32'h70, 0, N);
      #2;
      check_all($sformatf("stall%0d", k), 32'h2, N, 32'h3, 1'b0, 1'b0, 32'h2);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, N);
    #2;
    check_all("release", 32'h2, N, 32'h3, 1'b0, 1'b0, 32'h2);
    @(negedge clk);
    #2;
    check_all("after_release", 32'h3, N, 32'h4, 1'b0, 1'b0, 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address loaded into PC on reset.
REQ-002 Parameter HALT_OPCODE, default 6'b111111, opcode field value (IM_RD[31:26]) that halts fetch.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Stall_F  input  1  hold PC and suppress all fetch state changes this cycle.
REQ-006 Branch_Taken_D  input  1  decode-resolved taken branch.
REQ-007 Branch_Target_D  input  32  branch target word address.
REQ-008 Jump_D  input  1  decode-resolved jump.
REQ-009 Jump_Target_D  input  32  jump target word address.
REQ-010 Resume  input  1  leave HALT state.
REQ-011 IM_RD  input  32  instruction memory read data for IM_Addr, combinational same cycle.
REQ-012 IM_Addr  output  32  instruction memory word address, equal to PC.
REQ-013 Instr_F  output  32  fetched instruction to the fetch/decode pipeline register.
REQ-014 PC_Plus_One_F  output  32  PC + 1, modulo 2^32.
REQ-015 Flush_D  output  1  tells fetch/decode register to load a NOP.
REQ-016 Halted  output  1  high while in HALT state.
REQ-017 Fetch_Count  output  32  count of instructions accepted into the pipeline.

Function
REQ-018 Block SHALL have two states, RUN and HALT; Halted SHALL equal (state == HALT), registered.
REQ-019 IM_Addr SHALL equal PC; PC_Plus_One_F SHALL equal PC + 1 with wrap from 32'hFFFF_FFFF to 0.
REQ-020 Redirect SHALL be (Branch_Taken_D | Jump_D) & ~Stall_F & (state == RUN).
REQ-021 Next-PC priority in RUN: Stall_F (hold) > Branch_Taken_D (Branch_Target_D) > Jump_D (Jump_Target_D) > halt detect (hold) > PC + 1.
REQ-022 Both Branch_Taken_D and Jump_D high with Stall_F low SHALL select Branch_Target_D.
REQ-023 Halt detect SHALL be IM_RD[31:26] == HALT_OPCODE & ~Stall_F & ~Redirect in RUN; next state HALT, PC held at halt instruction address.
REQ-024 In HALT, PC SHALL hold and branch/jump/stall inputs SHALL be ignored; Resume high moves to RUN with PC <= PC + 1 next cycle.
REQ-025 Resume SHALL be ignored in RUN.
REQ-026 Instr_F SHALL equal IM_RD in RUN, except 32'h0000_0000 (NOP) when halt detect is true, and SHALL be 32'h0000_0000 in HALT.
REQ-027 Flush_D SHALL equal Redirect (combinational), so the wrong-path instruction is squashed in the same cycle.
REQ-028 Fetch_Count SHALL increment by 1 in each cycle where state == RUN, Stall_F low, Redirect low and halt detect false; it SHALL saturate at 32'hFFFF_FFFF.
REQ-029 Stall_F SHALL freeze PC, state and Fetch_Count; Instr_F and PC_Plus_One_F SHALL still reflect the held PC.
REQ-030 Fetch latency SHALL be zero cycles: the instruction at IM_Addr appears on Instr_F in the same cycle.

Reset
REQ-031 reset high at posedge SHALL set PC = RESET_PC, state = RUN, Fetch_Count = 0, overriding every other input, including during HALT or Stall_F.
REQ-032 During reset, outputs SHALL follow REQ-019/026/027 from the reset PC; Flush_D SHALL be 0 and Halted 0 the cycle after reset.
REQ-033 Reset asserted mid-redirect SHALL discard the redirect target.

Verification
REQ-034 Reset, then 4 cycles of IM_RD = 32'h2001_0005, no stall -> IM_Addr 0,1,2,3,4; Fetch_Count 4; Flush_D 0.
REQ-035 PC = 7, Branch_Taken_D = 1, Branch_Target_D = 32'h40, Jump_D = 1, Jump_Target_D = 32'h80 -> Flush_D 1 that cycle, next IM_Addr 32'h40, Fetch_Count unchanged.
REQ-036 PC = 5, Stall_F = 1 for 3 cycles with Branch_Taken_D = 1 -> IM_Addr stays 5, Flush_D 0, Fetch_Count frozen; after release, PC 6.
REQ-037 IM_RD = 32'hFC00_0000 at PC = 9 -> Instr_F 0, next cycle Halted 1, IM_Addr 9; Jump_D ignored; Resume pulse -> Halted 0, IM_Addr 10.
REQ-038 Preload PC = 32'hFFFF_FFFF (via branch target) -> PC_Plus_One_F 0, next IM_Addr 0.
REQ-039 reset asserted while Halted with Stall_F = 1 -> next cycle IM_Addr = RESET_PC, Halted 0, Fetch_Count 0.
